// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op and state encodings,
// the store-op set and per-op alignment masks.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  // Bit n set means op encoding n is a store.
  localparam logic [7:0] STORE_OPS = 8'b1110_0000;

  // Address bits [1:0] that must be zero for each access size.
  localparam logic [1:0] ALIGN_W = 2'b11;
  localparam logic [1:0] ALIGN_H = 2'b01;
  localparam logic [1:0] ALIGN_B = 2'b00;

  function automatic logic is_store(input op_e op);
    return STORE_OPS[op];
  endfunction

  function automatic logic [1:0] align_mask(input op_e op);
    case (op)
      OP_LW, OP_SW:         return ALIGN_W;
      OP_LH, OP_LHU, OP_SH: return ALIGN_H;
      default:              return ALIGN_B;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: extract+extend a load result from a memory word,
// and merge sub-word store data into a memory word for read-modify-write.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr[1] ? word[31:16] : word[15:0];

    load_data = '0;
    case (op_e'(op))
      OP_LW:   load_data = word;
      OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_data = {16'h0000, lane_h};
      OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_data = {24'h000000, lane_b};
      default: load_data = '0;
    endcase

    // Word stores pass the data through; sub-word stores keep the other lanes.
    merged = wdata;
    case (op_e'(op))
      OP_SH: merged = addr[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      OP_SB: begin
        merged = word;
        case (addr)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX and a word-wide data memory: sub-word loads with
// extension, sub-word stores by read-modify-write, misaligned requests rejected.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, the requester holds req_valid until taken,
// and completion is a one-cycle resp_valid pulse with resp_rdata/resp_err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_RD_LAT = 1,
  parameter bit WORD_INDEX = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_data,
  output logic              mem_MW,
  output logic              mem_MD,
  input  logic [31:0]       mem_out
);

  localparam int              CNT_W    = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_RD_LAT - 1);

  state_e            state, state_n;
  op_e               op_q, op_n;
  logic [1:0]        lane_q, lane_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  logic              req_ready_n, resp_valid_n, resp_err_n, mem_mw_n, mem_md_n;
  logic [31:0]       resp_rdata_n, mem_address_n, mem_data_n;
  logic [31:0]       load_data, merged;
  logic              misaligned;
  op_e               req_op_e;

  // Addresses near the top of the byte space simply truncate; no carry out.
  function automatic logic [31:0] word_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] w;
    if (WORD_INDEX) w = a >> 2;
    else            w = a & {{(ADDR_W-2){1'b1}}, 2'b00};
    return 32'(w);
  endfunction

  lsu_byte_lane u_lane (
    .word      (mem_out),
    .addr      (lane_q),
    .op        (op_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign req_op_e   = op_e'(req_op);
  assign misaligned = (req_addr[1:0] & align_mask(req_op_e)) != 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= OP_LW;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      cnt         <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_MW      <= 1'b0;
      mem_MD      <= 1'b0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      lane_q      <= lane_n;
      wdata_q     <= wdata_n;
      cnt         <= cnt_n;
      req_ready   <= req_ready_n;
      resp_valid  <= resp_valid_n;
      resp_rdata  <= resp_rdata_n;
      resp_err    <= resp_err_n;
      mem_address <= mem_address_n;
      mem_data    <= mem_data_n;
      mem_MW      <= mem_mw_n;
      mem_MD      <= mem_md_n;
    end
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_n       = state;
    op_n          = op_q;
    lane_n        = lane_q;
    wdata_n       = wdata_q;
    cnt_n         = cnt;
    resp_valid_n  = 1'b0;
    resp_rdata_n  = '0;
    resp_err_n    = 1'b0;
    mem_address_n = mem_address;
    mem_data_n    = mem_data;
    mem_mw_n      = 1'b0;
    mem_md_n      = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_n    = req_op_e;
          lane_n  = req_addr[1:0];
          wdata_n = req_wdata;
          if (misaligned) begin
            state_n      = S_RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
          end else if (req_op_e == OP_SW) begin
            state_n       = S_WR;
            mem_mw_n      = 1'b1;
            mem_address_n = word_addr(req_addr);
            mem_data_n    = req_wdata;
          end else begin
            state_n       = S_RD;
            mem_md_n      = 1'b1;
            cnt_n         = CNT_INIT;
            mem_address_n = word_addr(req_addr);
          end
        end
      end
      // MD was pulsed on entry; stay here until the read data has arrived.
      S_RD: begin
        if (cnt == '0) state_n = S_CAP;
        else           cnt_n   = cnt - 1'b1;
      end
      S_CAP: begin
        if (is_store(op_q)) begin
          state_n    = S_WR;
          mem_mw_n   = 1'b1;
          mem_data_n = merged;
        end else begin
          state_n      = S_RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = load_data;
        end
      end
      S_WR: begin
        state_n      = S_RESP;
        resp_valid_n = 1'b1;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    req_ready_n = (state_n == S_IDLE);
  end

endmodule
